// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: holds the fetch PC for the MMU and queues {pc, instr} toward decode.
// Optional FETCH_BYPASS_EN: an empty queue forwards the returning word to out_* in the same cycle.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        mmu_fetch_ok,
   input  logic [63:0] mmu_data,
   output logic [63:0] pc_o,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic {FETCH, REDIR} state_t;

   state_t        state, state_next;
   logic [63:0]   fetch_pc, fetch_pc_next;
   logic [63:0]   pending_pc, pending_pc_next;
   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [63:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];

   logic [63:0] target;
   logic [31:0] instr;
   logic        fifo_valid, pop, push, wr_en, bypass;

   assign target     = redirect_pc & ~64'd3;
   assign instr      = fetch_pc[2] ? mmu_data[63:32] : mmu_data[31:0];
   assign fifo_valid = (count != '0);
   assign pop        = fifo_valid & out_ready & ~redirect_valid;
   assign push       = mmu_fetch_ok & (state == FETCH) & ~redirect_valid
                       & ((count < CW'(DEPTH)) | pop);
`ifdef FETCH_BYPASS_EN
   assign bypass = push & ~fifo_valid;
`else
   assign bypass = 1'b0;
`endif
   // A bypassed word taken by decode in the same cycle never enters the FIFO.
   assign wr_en = push & ~(bypass & out_ready);
   assign pc_o  = fetch_pc;

   always_comb begin
      out_valid = fifo_valid | bypass;
      out_pc    = '0;
      out_instr = '0;
      if (fifo_valid) begin
         out_pc    = mem_pc[rd_ptr];
         out_instr = mem_instr[rd_ptr];
      end else if (bypass) begin
         out_pc    = fetch_pc;
         out_instr = instr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         fetch_pc   <= RESET_PC;
         pending_pc <= '0;
      end else begin
         state      <= state_next;
         fetch_pc   <= fetch_pc_next;
         pending_pc <= pending_pc_next;
      end
   end

   // Redirects without a returning word park the target so the in-flight walk keeps its PC.
   always_comb begin
      state_next      = state;
      fetch_pc_next   = fetch_pc;
      pending_pc_next = pending_pc;
      case (state)
         FETCH: begin
            if (redirect_valid) begin
               if (mmu_fetch_ok) begin
                  fetch_pc_next = target;
               end else begin
                  pending_pc_next = target;
                  state_next      = REDIR;
               end
            end else if (push) begin
               fetch_pc_next = fetch_pc + 64'd4;
            end
         end
         REDIR: begin
            if (redirect_valid) begin
               pending_pc_next = target;
               if (mmu_fetch_ok) begin
                  fetch_pc_next = target;
                  state_next    = FETCH;
               end
            end else if (mmu_fetch_ok) begin
               fetch_pc_next = pending_pc;
               state_next    = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (redirect_valid) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc[wr_ptr]    <= fetch_pc;
         mem_instr[wr_ptr] <= instr;
      end
   end

endmodule
